// File: rtl/tamagotchi_needs_fsm.sv
// tamagotchi_needs_fsm: pet-state core with decaying need levels, feed buttons and a registered mood FSM
// Optional feature: define TAMA_SLEEP_EN to add the SLEEP mood (code 101).
// Ports:
//   clk          system clock, rising edge
//   btn_reset    synchronous active-high reset
//   btn_need     per-need feed buttons (level, pre-debounced)
//   btn_test     test-mode button, hold HOLD_CYC cycles to toggle
//   level_out    packed levels, need i at [i*LVL_W +: LVL_W]
//   need_idx     index of the lowest level, ties go to the lowest index
//   test_mode    accelerated decay active
//   display_out  mood: 000 HAPPY 001 NEEDY 010 CRITICAL 011 DEAD 101 SLEEP
module tamagotchi_needs_fsm #(
  parameter int N_NEEDS    = 4,
  parameter int LVL_W      = 3,
  parameter int FEED_STEP  = 2,
  parameter int THR_OK     = 4,
  parameter int THR_CRIT   = 2,
  parameter int TICK_DIV   = 1000,
  parameter int TEST_DIV   = 10,
  parameter int HOLD_CYC   = 50,
  parameter int DEAD_TICKS = 3
) (
  input  logic                       clk,
  input  logic                       btn_reset,
  input  logic [N_NEEDS-1:0]         btn_need,
  input  logic                       btn_test,
  output logic [N_NEEDS*LVL_W-1:0]   level_out,
  output logic [$clog2(N_NEEDS)-1:0] need_idx,
  output logic                       test_mode,
  output logic [2:0]                 display_out
);
  localparam int LVL_MAX = 2**LVL_W - 1;
  localparam int SW = LVL_W + 2;
  localparam int IW = $clog2(N_NEEDS);
  localparam int PW = $clog2(TICK_DIV > TEST_DIV ? TICK_DIV : TEST_DIV);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int DW = $clog2(DEAD_TICKS + 1);
  localparam logic signed [SW-1:0] S_MAX = SW'(LVL_MAX);
  typedef enum logic [2:0] {
    S_HAPPY = 3'b000,
    S_NEEDY = 3'b001,
    S_CRIT  = 3'b010,
    S_DEAD  = 3'b011,
    S_SLEEP = 3'b101
  } state_t;
  state_t                r_state;
  logic [LVL_W-1:0]      r_level [N_NEEDS];
  logic [N_NEEDS-1:0]    r_btn_q;
  logic [PW-1:0]         r_presc;
  logic [HW-1:0]         r_hold;
  logic [DW-1:0]         r_dead;
  logic                  r_test;
  logic [IW-1:0]         r_need_idx;
  logic [N_NEEDS-1:0]    w_press;
  logic                  w_tick;
  logic                  w_dec;
  logic                  w_feed;
  logic                  w_any0;
  logic                  w_toggle;
  logic signed [SW-1:0]  w_sum;
  logic [LVL_W-1:0]      w_next [N_NEEDS];
  logic [LVL_W-1:0]      w_min;
  logic [IW-1:0]         w_min_idx;
  state_t                w_mood;
  assign w_press  = btn_need & ~r_btn_q;
  assign w_tick   = r_presc == (r_test ? PW'(TEST_DIV - 1) : PW'(TICK_DIV - 1));
  assign w_toggle = btn_test && r_hold == HW'(HOLD_CYC - 1);
`ifdef TAMA_SLEEP_EN
  logic [3:0] r_idle;
  logic       r_half;
  // asleep: presses only wake the pet, decay lands on every second tick
  assign w_feed = r_state != S_DEAD && r_state != S_SLEEP;
  assign w_dec  = w_tick && r_state != S_DEAD && (r_state != S_SLEEP || r_half);
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      r_idle <= '0;
      r_half <= 1'b0;
    end else begin
      r_idle <= |w_press ? 4'd0 : (w_tick && r_idle != 4'd8) ? r_idle + 4'd1 : r_idle;
      r_half <= r_state != S_SLEEP ? 1'b0 : w_tick ? ~r_half : r_half;
    end
  end
`else
  assign w_feed = r_state != S_DEAD;
  assign w_dec  = w_tick && r_state != S_DEAD;
`endif
  // widened signed sum so a feed at LVL_MAX or a decay at 0 clamps instead of wrapping
  always_comb begin
    w_any0 = 1'b0;
    w_sum  = '0;
    for (int i = 0; i < N_NEEDS; i++) begin
      w_sum = $signed({2'b00, r_level[i]})
            + ((w_feed && w_press[i]) ? SW'(FEED_STEP) : SW'(0))
            - (w_dec ? SW'(1) : SW'(0));
      w_next[i] = w_sum[SW-1] ? '0 : (w_sum > S_MAX) ? LVL_W'(LVL_MAX) : w_sum[LVL_W-1:0];
      w_any0 = w_any0 | (w_next[i] == '0);
    end
  end
  always_comb begin
    w_min     = r_level[0];
    w_min_idx = '0;
    for (int i = 1; i < N_NEEDS; i++) begin
      if (r_level[i] < w_min) begin
        w_min     = r_level[i];
        w_min_idx = IW'(i);
      end
    end
    w_mood = int'(w_min) >= THR_OK ? S_HAPPY : int'(w_min) >= THR_CRIT ? S_NEEDY : S_CRIT;
  end
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      for (int i = 0; i < N_NEEDS; i++) r_level[i] <= LVL_W'(LVL_MAX);
      r_btn_q <= '0;
      r_presc <= '0;
      r_hold  <= '0;
      r_dead  <= '0;
      r_test  <= 1'b0;
    end else begin
      for (int i = 0; i < N_NEEDS; i++) r_level[i] <= w_next[i];
      r_btn_q <= btn_need;
      r_presc <= (w_toggle || w_tick) ? '0 : r_presc + 1'b1;
      r_hold  <= !btn_test ? '0 : (r_hold == HW'(HOLD_CYC)) ? r_hold : r_hold + 1'b1;
      if (w_toggle) r_test <= ~r_test;
      if (w_tick) r_dead <= !w_any0 ? '0 : (r_dead == DW'(DEAD_TICKS)) ? r_dead : r_dead + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (btn_reset) begin
      r_state    <= S_HAPPY;
      r_need_idx <= '0;
    end else begin
      r_need_idx <= w_min_idx;
      r_state <= (r_state == S_DEAD || r_dead == DW'(DEAD_TICKS)) ? S_DEAD
`ifdef TAMA_SLEEP_EN
               : (r_state == S_SLEEP) ? (|w_press ? w_mood : S_SLEEP)
               : (r_state != S_CRIT && r_idle == 4'd8) ? S_SLEEP
`endif
               : w_mood;
    end
  end
  for (genvar g = 0; g < N_NEEDS; g++) begin : g_pack
    assign level_out[g*LVL_W +: LVL_W] = r_level[g];
  end
  assign need_idx    = r_need_idx;
  assign test_mode   = r_test;
  assign display_out = r_state;
endmodule
